// File: rtl/pc_fetch_if.sv
// Fetch-side bundle: redirect input from the next-PC mux, the imem req/ack bus,
// and the decode valid/ready bus. The fetch unit uses "master", its neighbours use "slave".
interface pc_fetch_if #(
    parameter int XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_err;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4, misalign_err
    );

    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4, misalign_err
    );
endinterface

// File: rtl/pc_fetch.sv
// PC register and fetch sequencer: one outstanding imem request, one held instruction.
// Optional macro PC_MISALIGN_CHECK_EN rejects redirects to non-word-aligned targets.
module pc_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic       clk,
    input  logic       rst,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;

    logic            redir_ok_d;
    logic [XLEN-1:0] target_pc_d;

`ifdef PC_MISALIGN_CHECK_EN
    logic            redir_bad_d;
    logic            err_q;

    always_comb begin
        target_pc_d = bus.redirect_pc;
        redir_ok_d  = bus.redirect && (bus.redirect_pc[1:0] == 2'b00);
        redir_bad_d = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= redir_bad_d;
    end

    assign bus.misalign_err = err_q;
`else
    always_comb begin
        target_pc_d = bus.redirect_pc & ~XLEN'(3);
        redir_ok_d  = bus.redirect;
    end

    assign bus.misalign_err = 1'b0;
`endif

    // imem_req/imem_addr come straight from flops so redirect/ready never reach the memory bus combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else if (redir_ok_d) begin
            pc_q    <= target_pc_d;
            valid_q <= 1'b0;
            case (state_q)
                REQ, DROP: begin
                    // Without ack the old request must still complete, so wait it out in DROP
                    if (bus.imem_ack) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= target_pc_d;
                    end else begin
                        state_q <= DROP;
                    end
                end
                default: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= target_pc_d;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        instr_q  <= bus.imem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + XLEN'(4);
                        req_q    <= 1'b0;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.pc_plus4    = pc_out_q + XLEN'(4);
endmodule
